// File: rtl/sort_pkg.sv
// Shared definitions for the 4-input sort network and its feeder/holding stages.
package sort_pkg;

  localparam int          SORT_W     = 8;
  localparam int          SORT_N     = 4;
  localparam int          SORT_CNT_W = 3;
  localparam logic [7:0]  SORT_PAD   = 8'hFF;

  // One group of four elements plus the number of real elements in it.
  typedef struct packed {
    logic [SORT_W-1:0]     d1;
    logic [SORT_W-1:0]     d2;
    logic [SORT_W-1:0]     d3;
    logic [SORT_W-1:0]     d4;
    logic [SORT_CNT_W-1:0] cnt;
  } sort_group_t;

  // Even parity over a group, for use by downstream integrity checks.
  function automatic logic group_parity(input sort_group_t g);
    return ^g;
  endfunction

endpackage

// File: rtl/sort_group_reg.sv
// One-entry valid/ready holding register for a packed sort group.
// Output valid and data come straight from flops; in_ready is free when
// the entry is empty or is being handed over this cycle.
module sort_group_reg
  import sort_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  sort_group_t in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output sort_group_t out_data
);

  typedef enum logic [0:0] {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  hold_state_t state_r;
  hold_state_t state_nxt_s;
  sort_group_t data_r;
  logic        load_s;

  // State and data registers; data only changes when a new group is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= HOLD_EMPTY;
      data_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        data_r <= in_data;
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Next-state: fill when a group arrives, empty when handed over with nothing behind it.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      HOLD_EMPTY: begin
        if (in_valid) begin
          state_nxt_s = HOLD_FULL;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = HOLD_EMPTY;
        end
      end
      HOLD_FULL: begin
        if (out_ready) begin
          if (in_valid) begin
            state_nxt_s = HOLD_FULL;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = HOLD_EMPTY;
          end
        end else begin
          state_nxt_s = HOLD_FULL;
        end
      end
      default: begin
        state_nxt_s = HOLD_EMPTY;
      end
    endcase
  end

  // Outputs: valid and data from flops, ready reflects whether the slot is free.
  always_comb begin
    out_valid = (state_r == HOLD_FULL);
    out_data  = data_r;
    if (state_r == HOLD_FULL) begin
      in_ready = out_ready;
    end else begin
      in_ready = 1'b1;
    end
  end

endmodule

// File: rtl/sort_group_loader.sv
// Packs a byte stream into groups of four for the sort network, padding
// short groups, with a hold stage on the output plus one pending group
// held in the fill array so input can stream at one byte per cycle.
module sort_group_loader
  import sort_pkg::*;
#(
  parameter int          W   = SORT_W,
  parameter logic [W-1:0] PAD = SORT_PAD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  input  logic         s_last,
  output logic         g_valid,
  input  logic         g_ready,
  output logic [W-1:0] g_d1,
  output logic [W-1:0] g_d2,
  output logic [W-1:0] g_d3,
  output logic [W-1:0] g_d4,
  output logic [2:0]   g_cnt
);

  logic [W-1:0] fill_r [0:3];
  logic [1:0]   fill_cnt_r;
  logic [2:0]   pend_cnt_r;
  logic         pending_r;
  logic         s_ready_r;

  logic         accept_s;
  logic         complete_s;
  logic         hold_free_s;
  logic         load_valid_s;
  logic [W-1:0] slot_s [0:3];
  sort_group_t  new_grp_s;
  sort_group_t  load_grp_s;
  sort_group_t  hold_grp_s;

  // Handshake decode and the group as it would look if closed with this byte.
  always_comb begin
    accept_s   = s_valid && !pending_r;
    complete_s = accept_s && ((fill_cnt_r == 2'd3) || s_last);
    for (int i = 0; i < 4; i++) begin
      if (i < int'(fill_cnt_r)) begin
        slot_s[i] = fill_r[i];
      end else if (i == int'(fill_cnt_r)) begin
        slot_s[i] = s_data;
      end else begin
        slot_s[i] = PAD;
      end
    end
    new_grp_s.d1  = slot_s[0];
    new_grp_s.d2  = slot_s[1];
    new_grp_s.d3  = slot_s[2];
    new_grp_s.d4  = slot_s[3];
    new_grp_s.cnt = {1'b0, fill_cnt_r} + 3'd1;
  end

  // Choose what is offered to the hold stage: a stalled group has priority.
  always_comb begin
    load_valid_s = pending_r || complete_s;
    if (pending_r) begin
      load_grp_s.d1  = fill_r[0];
      load_grp_s.d2  = fill_r[1];
      load_grp_s.d3  = fill_r[2];
      load_grp_s.d4  = fill_r[3];
      load_grp_s.cnt = pend_cnt_r;
    end else begin
      load_grp_s = new_grp_s;
    end
  end

  // Fill array, fill count and pending flag; a group that cannot move is parked here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt_r <= 2'd0;
      pend_cnt_r <= 3'd0;
      pending_r  <= 1'b0;
      s_ready_r  <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        fill_r[i] <= '0;
      end
    end else if (pending_r) begin
      if (hold_free_s) begin
        pending_r  <= 1'b0;
        s_ready_r  <= 1'b1;
        fill_cnt_r <= 2'd0;
      end
    end else if (accept_s) begin
      if (complete_s) begin
        fill_cnt_r <= 2'd0;
        if (!hold_free_s) begin
          pending_r  <= 1'b1;
          s_ready_r  <= 1'b0;
          pend_cnt_r <= new_grp_s.cnt;
          for (int i = 0; i < 4; i++) begin
            fill_r[i] <= slot_s[i];
          end
        end
      end else begin
        fill_r[fill_cnt_r] <= s_data;
        fill_cnt_r         <= fill_cnt_r + 2'd1;
      end
    end
  end

  sort_group_reg u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (load_valid_s),
    .in_ready  (hold_free_s),
    .in_data   (load_grp_s),
    .out_valid (g_valid),
    .out_ready (g_ready),
    .out_data  (hold_grp_s)
  );

  assign s_ready = s_ready_r;
  assign g_d1    = hold_grp_s.d1;
  assign g_d2    = hold_grp_s.d2;
  assign g_d3    = hold_grp_s.d3;
  assign g_d4    = hold_grp_s.d4;
  assign g_cnt   = hold_grp_s.cnt;

endmodule

// File: tb/tb_sort_group_loader.sv
// Bench for sort_group_loader: directed scenarios plus randomized traffic,
// checked against a transaction-level model (queue of finished groups).
module tb_sort_group_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       g_valid;
  logic       g_ready;
  logic [7:0] g_d1, g_d2, g_d3, g_d4;
  logic [2:0] g_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model: bytes of the open group, and finished groups not yet consumed
  // (front = what the output should show; at most two may wait).
  logic [7:0]  part_q[$];
  logic [34:0] grp_q[$];
  bit          after_reset;

  sort_group_loader dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .g_valid(g_valid), .g_ready(g_ready),
    .g_d1(g_d1), .g_d2(g_d2), .g_d3(g_d3), .g_d4(g_d4), .g_cnt(g_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every visible output against the model.
  task automatic compare_outputs();
    logic [34:0] g;
    check("s_ready", {31'd0, s_ready}, {31'd0, (grp_q.size() < 2)});
    check("g_valid", {31'd0, g_valid}, {31'd0, (grp_q.size() > 0)});
    if (grp_q.size() > 0) begin
      g = grp_q[0];
      check("g_d1", {24'd0, g_d1}, {24'd0, g[34:27]});
      check("g_d2", {24'd0, g_d2}, {24'd0, g[26:19]});
      check("g_d3", {24'd0, g_d3}, {24'd0, g[18:11]});
      check("g_d4", {24'd0, g_d4}, {24'd0, g[10:3]});
      check("g_cnt", {29'd0, g_cnt}, {29'd0, g[2:0]});
    end else if (after_reset) begin
      check("rst_g", {g_d1, g_d2, g_d3, g_d4}, 32'd0);
      check("rst_cnt", {29'd0, g_cnt}, 32'd0);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic gr, input logic rn);
    bit acc, xfer;
    logic [34:0] g;
    s_valid = v; s_data = d; s_last = l; g_ready = gr; rst_n = rn;
    acc  = rn && v && (grp_q.size() < 2);
    xfer = rn && gr && (grp_q.size() > 0);
    @(posedge clk);
    if (!rn) begin
      part_q.delete();
      grp_q.delete();
      after_reset = 1'b1;
    end else begin
      if (xfer) void'(grp_q.pop_front());
      if (acc) begin
        part_q.push_back(d);
        if (part_q.size() == 4 || l) begin
          for (int i = 0; i < 4; i++) begin
            g[34 - 8*i -: 8] = (i < part_q.size()) ? part_q[i] : 8'hFF;
          end
          g[2:0] = 3'(part_q.size());
          grp_q.push_back(g);
          part_q.delete();
        end
      end
      if (grp_q.size() > 0) after_reset = 1'b0;
    end
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    int gr_pct, v_pct;
    s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0; g_ready = 1'b0; rst_n = 1'b0;
    after_reset = 1'b0;
    @(negedge clk);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Basic group: 13,1,23,10 with consumer ready.
    step(1'b1, 8'd13, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd1,  1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd23, 1'b0, 1'b1, 1'b1);
    check("basic_novalid", {31'd0, g_valid}, 32'd0);
    step(1'b1, 8'd10, 1'b0, 1'b1, 1'b1);
    check("basic_grp", {g_d1, g_d2, g_d3, g_d4}, {8'd13, 8'd1, 8'd23, 8'd10});
    check("basic_cnt", {29'd0, g_cnt}, 32'd4);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);

    // Streaming 1..8.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);

    // Short group 7,3 closed by s_last.
    step(1'b1, 8'd7, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd3, 1'b1, 1'b0, 1'b1);
    check("short_grp", {g_d1, g_d2, g_d3, g_d4}, {8'd7, 8'd3, 8'hFF, 8'hFF});
    check("short_cnt", {29'd0, g_cnt}, 32'd2);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);

    // Backpressure: 1..8 with consumer stalled, then one ready cycle.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    check("bp_stall", {31'd0, s_ready}, 32'd0);
    step(1'b1, 8'd99, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    check("bp_release", {g_d1, g_d2, g_d3, g_d4}, {8'd5, 8'd6, 8'd7, 8'd8});
    check("bp_ready", {31'd0, s_ready}, 32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);

    // Reset mid-group.
    step(1'b1, 8'd9, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd9, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
    for (int i = 4; i >= 1; i--) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    check("rst_grp", {g_d1, g_d2, g_d3, g_d4}, {8'd4, 8'd3, 8'd2, 8'd1});
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);

    // Lone s_last produces nothing.
    step(1'b0, 8'd5, 1'b1, 1'b1, 1'b1);
    step(1'b0, 8'd5, 1'b1, 1'b1, 1'b1);
    check("lone_last", {31'd0, g_valid}, 32'd0);

    // Randomized traffic in phases of varying pressure.
    for (int ph = 0; ph < 12; ph++) begin
      gr_pct = $urandom_range(100, 10);
      v_pct  = $urandom_range(100, 30);
      for (int c = 0; c < 300; c++) begin
        step(($urandom_range(99, 0) < v_pct),
             8'($urandom),
             ($urandom_range(5, 0) == 0),
             ($urandom_range(99, 0) < gr_pct),
             ($urandom_range(399, 0) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
